y86_fetch_unit: RTL

- Parametrised fetch stage for the Y86-64 pipeline. Owns the F register (predicted PC), a writable byte-wide instruction memory, PC selection, instruction-length decode and the F/D pipeline register.
- Beyond the existing fetch stage, it adds:
  - a selectable branch-prediction mode with an explicit alternate-target path;
  - a fetch-stop latch after HLT, ADR or INS;
  - a reset-initialised PC;
  - saturating fetch and mispredict counters.

---
 rtl/y86_fetch_unit.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit
//   Fetch stage of a Y86-64 pipeline. Holds the predicted PC (F register),
//   a byte-wide writable instruction memory, PC selection, instruction-length
//   decode, jXX prediction and the F/D pipeline register. It also has a
//   fetch-stop latch and two saturating performance counters.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_we/imem_waddr/imem_wdata   synchronous byte write into the instruction memory
//   F_stall                         hold the predicted PC
//   D_stall, D_bubble               hold the D register / load a nop into it
//   M_icode/M_ifun/M_cnd/
//   M_predTaken/M_altPC             resolved jXX in memory stage (mispredict redirect)
//   W_icode, W_valM                 ret in write-back and its return address
//   f_pc                            selected fetch PC (combinational)
//   D_*                             F/D pipeline register contents
//   fetch_stopped                   fetch-stop latch
//   instr_count, mispredict_count   saturating performance counters
module y86_fetch_unit #(
    parameter int          IMEM_DEPTH = 1024,
    parameter int          AW         = 10,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          PRED_MODE  = 0,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_we,
    input  logic [AW-1:0]    imem_waddr,
    input  logic [7:0]       imem_wdata,
    input  logic             F_stall,
    input  logic             D_stall,
    input  logic             D_bubble,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       M_ifun,
    input  logic             M_cnd,
    input  logic             M_predTaken,
    input  logic [63:0]      M_altPC,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valM,
    output logic [63:0]      f_pc,
    output logic [2:0]       D_stat,
    output logic [3:0]       D_icode,
    output logic [3:0]       D_ifun,
    output logic [3:0]       D_rA,
    output logic [3:0]       D_rB,
    output logic [63:0]      D_valC,
    output logic [63:0]      D_valP,
    output logic             D_predTaken,
    output logic [63:0]      D_altPC,
    output logic             fetch_stopped,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
                           I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
                           I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
    localparam logic [3:0] R_NONE = 4'hF;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    typedef struct packed {
        stat_e       stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        pred_taken;
        logic [63:0] alt_pc;
    } d_reg_t;

    localparam d_reg_t D_NOP = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0, ra: R_NONE, rb: R_NONE,
                                 valc: 64'h0, valp: 64'h0, pred_taken: 1'b0, alt_pc: 64'h0};

    // Instruction memory
    logic [7:0] imem [IMEM_DEPTH];

    // NOTE: the memory array has no reset; program contents survive rst_n and a
    // reset loop over every entry would not map onto a RAM.
    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

    // PC selection: ret beats mispredict beats prediction
    logic [63:0] f_pred_pc_q, f_pred_pc_d;
    logic        ret_redirect, mispredict, redirect;

    assign ret_redirect = (W_icode == I_RET);
    assign mispredict   = (M_icode == I_JXX) && (M_ifun != 4'h0) && (M_cnd != M_predTaken);
    assign redirect     = ret_redirect || mispredict;
    assign f_pc         = ret_redirect ? W_valM : (mispredict ? M_altPC : f_pred_pc_q);

    // Ten-byte fetch window; bytes outside the memory read as zero
    logic [79:0] fetch_bytes;

    always_comb begin : imem_read
        logic [63:0] byte_addr;
        fetch_bytes = '0;
        for (int k = 0; k < 10; k++) begin
            byte_addr = f_pc + 64'(k);
            if (byte_addr < 64'(IMEM_DEPTH)) fetch_bytes[8*k +: 8] = imem[byte_addr[AW-1:0]];
        end
    end

    // Decode, status and prediction
    d_reg_t      fetched;
    logic [3:0]  len;
    logic        has_regs;
    logic [64:0] end_addr;
    logic [63:0] f_pred_pc;

    // NOTE: every signal written here gets a default before the case so that no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        fetched       = D_NOP;
        fetched.icode = fetch_bytes[7:4];
        fetched.ifun  = fetch_bytes[3:0];
        len           = 4'd1;
        has_regs      = 1'b0;
        f_pred_pc     = 64'h0;

        case (fetched.icode)
            I_HALT, I_NOP, I_RET:           len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                len      = 4'd2;
                has_regs = 1'b1;
            end
            I_JXX, I_CALL: begin
                len          = 4'd9;
                fetched.valc = fetch_bytes[71:8];
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len          = 4'd10;
                has_regs     = 1'b1;
                fetched.valc = fetch_bytes[79:16];
            end
            default:                        len = 4'd1;
        endcase

        if (has_regs) begin
            fetched.ra = fetch_bytes[15:12];
            fetched.rb = fetch_bytes[11:8];
        end
        fetched.valp = f_pc + 64'(len);

        // 65-bit end address so that a window wrapping past 2^64 is ADR too
        end_addr = {1'b0, f_pc} + 65'(len) - 65'd1;
        if (fetched.icode > I_POPQ)            fetched.stat = STAT_INS;
        else if (end_addr >= 65'(IMEM_DEPTH))  fetched.stat = STAT_ADR;
        else if (fetched.icode == I_HALT)      fetched.stat = STAT_HLT;
        else                                   fetched.stat = STAT_AOK;

        if (fetched.icode == I_CALL || (fetched.icode == I_JXX && fetched.ifun == 4'h0))
            fetched.pred_taken = 1'b1;
        else if (fetched.icode == I_JXX)
            fetched.pred_taken = (PRED_MODE == 0) ? 1'b1 : (fetched.valc < f_pc);

        f_pred_pc      = fetched.pred_taken ? fetched.valc : fetched.valp;
        // Only a not-taken conditional jump keeps valC as its alternate target
        fetched.alt_pc = (fetched.icode == I_JXX && !fetched.pred_taken) ? fetched.valc
                                                                          : fetched.valp;
    end

    // Next-state for F, D, stop latch and counters
    d_reg_t           d_q, d_d;
    logic             fetch_stopped_q, fetch_stopped_d;
    logic             load;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    always_comb begin
        d_d             = d_q;
        fetch_stopped_d = fetch_stopped_q;
        load            = 1'b0;
        f_pred_pc_d     = F_stall ? f_pred_pc_q : f_pred_pc;

        if (redirect) fetch_stopped_d = 1'b0;

        if (D_stall) begin
            d_d = d_q;
        end else if (D_bubble) begin
            d_d = D_NOP;
        end else if (fetch_stopped_q && !redirect) begin
            d_d = D_NOP;
        end else begin
            d_d  = fetched;
            load = 1'b1;
            if (fetched.stat != STAT_AOK) fetch_stopped_d = 1'b1;
        end

        instr_count_d = instr_count_q;
        if (load && instr_count_q != '1) instr_count_d = instr_count_q + CNT_W'(1);

        mispredict_count_d = mispredict_count_q;
        if (mispredict && !ret_redirect && mispredict_count_q != '1)
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pred_pc_q        <= RESET_PC;
            d_q                <= D_NOP;
            fetch_stopped_q    <= 1'b0;
            instr_count_q      <= '0;
            mispredict_count_q <= '0;
        end else begin
            f_pred_pc_q        <= f_pred_pc_d;
            d_q                <= d_d;
            fetch_stopped_q    <= fetch_stopped_d;
            instr_count_q      <= instr_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign D_stat           = d_q.stat;
    assign D_icode          = d_q.icode;
    assign D_ifun           = d_q.ifun;
    assign D_rA             = d_q.ra;
    assign D_rB             = d_q.rb;
    assign D_valC           = d_q.valc;
    assign D_valP           = d_q.valp;
    assign D_predTaken      = d_q.pred_taken;
    assign D_altPC          = d_q.alt_pc;
    assign fetch_stopped    = fetch_stopped_q;
    assign instr_count      = instr_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
